// File: rtl/whack_scorer.sv
// Whack-a-mole scoring engine: edge-detects button presses against the lit moles,
// allows one scoring action per round and tracks saturating score and hit streaks.
module whack_scorer #(
  parameter int N_MOLES      = 5,
  parameter int SCORE_W      = 8,
  parameter int STREAK_W     = 6,
  parameter int HIT_POINTS   = 1,
  parameter int MISS_PENALTY = 1,
  parameter int BONUS_EVERY  = 5
) (
  input  logic                MHz100_clk_i,
  input  logic                reset_n_i,
  input  logic                round_tick_i,
  input  logic                game_en_i,
  input  logic                clear_i,
  input  logic [N_MOLES-1:0]  LED_i,
  input  logic [N_MOLES-1:0]  whack_i,
  output logic [SCORE_W-1:0]  score_o,
  output logic [STREAK_W-1:0] streak_o,
  output logic [STREAK_W-1:0] best_streak_o,
  output logic                hit_o,
  output logic                miss_o,
  output logic                escape_o,
  output logic                locked_o
);

  typedef enum logic {ARMED = 1'b0, LOCKED = 1'b1} state_t;

  localparam int SUM_W = SCORE_W + 2;
  localparam logic [SUM_W-1:0] SCORE_MAX = {2'b00, {SCORE_W{1'b1}}};

  state_t              state_reg;
  logic [N_MOLES-1:0]  whack_q_reg;
  logic [SCORE_W-1:0]  score_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic [STREAK_W-1:0] best_reg;
  logic                hit_reg;
  logic                miss_reg;
  logic                escape_reg;

  logic [N_MOLES-1:0]  press;
  logic                press_any;
  logic                press_lit;
  logic [STREAK_W:0]   streak_plus;
  logic [STREAK_W-1:0] streak_hit_next;
  logic                bonus;
  logic [SUM_W-1:0]    score_sum;
  logic [SCORE_W-1:0]  score_hit_next;
  logic [SCORE_W-1:0]  score_miss_next;

  for (genvar gi = 0; gi < N_MOLES; gi++) begin : g_press
    assign press[gi] = whack_i[gi] & ~whack_q_reg[gi];
  end

  assign press_any = |press;
  assign press_lit = |(press & LED_i);

  assign streak_plus     = {1'b0, streak_reg} + 1'b1;
  assign streak_hit_next = streak_plus[STREAK_W] ? {STREAK_W{1'b1}} : streak_plus[STREAK_W-1:0];

  // Bonus uses the unsaturated next streak so the cadence is exact below saturation.
  if (BONUS_EVERY != 0) begin : g_bonus
    assign bonus = ((32'(streak_plus) % BONUS_EVERY) == 0);
  end else begin : g_no_bonus
    assign bonus = 1'b0;
  end

  assign score_sum       = {2'b00, score_reg} + SUM_W'(HIT_POINTS) + SUM_W'(bonus);
  assign score_hit_next  = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign score_miss_next = ({2'b00, score_reg} >= SUM_W'(MISS_PENALTY))
                         ? score_reg - SCORE_W'(MISS_PENALTY) : '0;

  always_ff @(posedge MHz100_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= ARMED;
      whack_q_reg <= '1;
      score_reg   <= '0;
      streak_reg  <= '0;
      best_reg    <= '0;
      hit_reg     <= 1'b0;
      miss_reg    <= 1'b0;
      escape_reg  <= 1'b0;
    end else begin
      whack_q_reg <= whack_i;
      hit_reg     <= 1'b0;
      miss_reg    <= 1'b0;
      escape_reg  <= 1'b0;
      if (clear_i) begin
        state_reg  <= ARMED;
        score_reg  <= '0;
        streak_reg <= '0;
        best_reg   <= '0;
      end else if (!game_en_i) begin
        state_reg <= ARMED;
      end else begin
        if (state_reg == ARMED) begin
          if (press_lit) begin
            hit_reg    <= 1'b1;
            state_reg  <= LOCKED;
            score_reg  <= score_hit_next;
            streak_reg <= streak_hit_next;
            if (streak_hit_next > best_reg) best_reg <= streak_hit_next;
          end else if (press_any) begin
            miss_reg   <= 1'b1;
            state_reg  <= LOCKED;
            score_reg  <= score_miss_next;
            streak_reg <= '0;
          end else if (round_tick_i && (|LED_i)) begin
            escape_reg <= 1'b1;
            streak_reg <= '0;
          end
        end
        // A round boundary always re-arms, overriding any lock taken this cycle.
        if (round_tick_i) state_reg <= ARMED;
      end
    end
  end

  assign score_o       = score_reg;
  assign streak_o      = streak_reg;
  assign best_streak_o = best_reg;
  assign hit_o         = hit_reg;
  assign miss_o        = miss_reg;
  assign escape_o      = escape_reg;
  assign locked_o      = (state_reg == LOCKED);

endmodule

// File: tb/tb_whack_scorer.sv
// Bench for whack_scorer: default instance plus a 4-bit-score instance sharing stimulus,
// both checked every cycle against an integer reference model of the scoring rules.
module tb_whack_scorer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       round_tick = 1'b0;
  logic       game_en = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] led = '0;
  logic [4:0] whack = '0;

  logic [7:0] score_a;
  logic [3:0] score_b;
  logic [5:0] streak_a, streak_b, best_a, best_b;
  logic       hit_a, hit_b, miss_a, miss_b, esc_a, esc_b, lock_a, lock_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int       m_score8, m_score4, m_streak, m_best;
  bit       m_locked, m_hit, m_miss, m_esc;
  bit [4:0] m_whack_q;

  always #5 clk = ~clk;

  whack_scorer u_dut_a (
    .MHz100_clk_i(clk), .reset_n_i(reset_n), .round_tick_i(round_tick), .game_en_i(game_en),
    .clear_i(clear), .LED_i(led), .whack_i(whack), .score_o(score_a), .streak_o(streak_a),
    .best_streak_o(best_a), .hit_o(hit_a), .miss_o(miss_a), .escape_o(esc_a), .locked_o(lock_a)
  );

  whack_scorer #(.SCORE_W(4)) u_dut_b (
    .MHz100_clk_i(clk), .reset_n_i(reset_n), .round_tick_i(round_tick), .game_en_i(game_en),
    .clear_i(clear), .LED_i(led), .whack_i(whack), .score_o(score_b), .streak_o(streak_b),
    .best_streak_o(best_b), .hit_o(hit_b), .miss_o(miss_b), .escape_o(esc_b), .locked_o(lock_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score8 = 0; m_score4 = 0; m_streak = 0; m_best = 0;
    m_locked = 0; m_hit = 0; m_miss = 0; m_esc = 0;
    m_whack_q = 5'b11111;
  endtask

  // One clock of the scoring rules, in plain integer arithmetic.
  task automatic model_step();
    bit [4:0] press;
    int       ns, pts;
    press = whack & ~m_whack_q;
    m_whack_q = whack;
    m_hit = 0; m_miss = 0; m_esc = 0;
    if (clear) begin
      m_score8 = 0; m_score4 = 0; m_streak = 0; m_best = 0; m_locked = 0;
    end else if (!game_en) begin
      m_locked = 0;
    end else begin
      if (!m_locked) begin
        if ((press & led) != 0) begin
          ns = m_streak + 1;
          pts = 1 + ((ns % 5 == 0) ? 1 : 0);
          m_streak = (ns > 63) ? 63 : ns;
          m_score8 = (m_score8 + pts > 255) ? 255 : m_score8 + pts;
          m_score4 = (m_score4 + pts > 15) ? 15 : m_score4 + pts;
          if (m_streak > m_best) m_best = m_streak;
          m_hit = 1; m_locked = 1;
        end else if (press != 0) begin
          m_streak = 0;
          m_score8 = (m_score8 >= 1) ? m_score8 - 1 : 0;
          m_score4 = (m_score4 >= 1) ? m_score4 - 1 : 0;
          m_miss = 1; m_locked = 1;
        end else if (round_tick && led != 0) begin
          m_streak = 0;
          m_esc = 1;
        end
      end
      if (round_tick) m_locked = 0;
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, " score_a"}, score_a, m_score8);
    check({ctx, " score_b"}, score_b, m_score4);
    check({ctx, " streak_a"}, streak_a, m_streak);
    check({ctx, " streak_b"}, streak_b, m_streak);
    check({ctx, " best_a"}, best_a, m_best);
    check({ctx, " best_b"}, best_b, m_best);
    check({ctx, " hit_a"}, hit_a, m_hit);
    check({ctx, " hit_b"}, hit_b, m_hit);
    check({ctx, " miss_a"}, miss_a, m_miss);
    check({ctx, " miss_b"}, miss_b, m_miss);
    check({ctx, " esc_a"}, esc_a, m_esc);
    check({ctx, " esc_b"}, esc_b, m_esc);
    check({ctx, " lock_a"}, lock_a, m_locked);
    check({ctx, " lock_b"}, lock_b, m_locked);
  endtask

  // Called at a negedge: apply inputs, clock once, compare just after the edge.
  task automatic step(input string ctx, input bit tick, input bit en, input bit clr,
                      input bit [4:0] l, input bit [4:0] w);
    round_tick = tick; game_en = en; clear = clr; led = l; whack = w;
    model_step();
    @(posedge clk);
    #1;
    check_all(ctx);
    $display("%s: tick=%0b en=%0b clr=%0b led=%05b whack=%05b -> score=%0d/%0d streak=%0d best=%0d hit=%0b miss=%0b esc=%0b lock=%0b",
             ctx, tick, en, clr, l, w, score_a, score_b, streak_a, best_a, hit_a, miss_a, esc_a, lock_a);
    @(negedge clk);
  endtask

  // One full hit round on mole b: press, release, round tick.
  task automatic hit_round(input string ctx, input int b);
    bit [4:0] m;
    m = 5'b00001 << b;
    step(ctx, 0, 1, 0, m, m);
    step(ctx, 0, 1, 0, m, 5'b00000);
    step(ctx, 1, 1, 0, m, 5'b00000);
  endtask

  bit [4:0] rw, rl;

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step("idle", 0, 1, 0, 5'b00100, 5'b00000);

    // Hit, then second edge on same lit bit before the tick is ignored
    step("hit1", 0, 1, 0, 5'b00100, 5'b00100);
    step("rel", 0, 1, 0, 5'b00100, 5'b00000);
    step("relock", 0, 1, 0, 5'b00100, 5'b00100);
    step("tick", 1, 1, 0, 5'b00100, 5'b00000);

    // Hit wins over miss; then a miss on unlit mole
    step("hitmiss", 0, 1, 0, 5'b00100, 5'b00101);
    step("rel", 0, 1, 0, 5'b00100, 5'b00000);
    step("tick", 1, 1, 0, 5'b00100, 5'b00000);
    step("miss", 0, 1, 0, 5'b00100, 5'b10000);
    step("tick", 1, 1, 0, 5'b00100, 5'b00000);

    // Five hits from zero: bonus on the fifth, then escape
    step("clear", 0, 1, 1, 5'b00000, 5'b00000);
    for (int i = 0; i < 5; i++) hit_round("streak", i);
    step("escape", 1, 1, 0, 5'b01000, 5'b00000);

    // Saturate the 4-bit score, then miss at zero
    for (int i = 0; i < 14; i++) hit_round("sat", i % 5);
    step("clear", 0, 1, 1, 5'b00000, 5'b00000);
    step("miss0", 0, 1, 0, 5'b00001, 5'b00010);
    step("tick", 1, 1, 0, 5'b00001, 5'b00000);

    // Press and tick together in ARMED, then in LOCKED
    step("ptick_armed", 1, 1, 0, 5'b00010, 5'b00010);
    step("rel", 0, 1, 0, 5'b00010, 5'b00000);
    step("lock", 0, 1, 0, 5'b00010, 5'b00010);
    step("rel", 0, 1, 0, 5'b00010, 5'b00000);
    step("ptick_locked", 1, 1, 0, 5'b00010, 5'b00010);

    // Disabled: edges do not score
    step("dis", 0, 0, 0, 5'b00010, 5'b00000);
    step("dis_edge", 0, 0, 0, 5'b00010, 5'b00010);
    step("en_held", 0, 1, 0, 5'b00010, 5'b00010);

    // Asynchronous reset mid-LOCKED with the button held through release
    step("rel", 1, 1, 0, 5'b00010, 5'b00000);
    step("prelock", 0, 1, 0, 5'b00010, 5'b00010);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    step("held", 0, 1, 0, 5'b00010, 5'b00010);

    // Randomised play
    rw = 5'b00010;
    rl = 5'b00010;
    for (int i = 0; i < 3000; i++) begin
      bit tk, en, cl;
      tk = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 15) != 0);
      cl = ($urandom_range(0, 199) == 0);
      if (tk) rl = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 7) == 0) rw[b] = ~rw[b];
      step("rand", tk, en, cl, rl, rw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/whack_scorer.md
Name: whack_scorer

Overview:
- Parametrised scoring engine for the whack-a-mole game, running entirely in the 100 MHz domain.
- Compares debounced button presses against the lit-mole vector and awards or penalises points.
- Allows one scoring action per round, re-armed by a synchronous round strobe from the game timer.
- Tracks current and best hit streaks and drives score/streak values to the display logic.

Parameters:
- N_MOLES, 5, number of mole LED/button channels.
- SCORE_W, 8, score width; score saturates at 2^SCORE_W-1.
- STREAK_W, 6, streak counter width; saturating.
- HIT_POINTS, 1, points added per hit.
- MISS_PENALTY, 1, points subtracted per wrong press; 0 disables penalties.
- BONUS_EVERY, 5, every BONUS_EVERY-th consecutive hit adds 1 extra point; 0 disables the bonus.

Ports:
- MHz100_clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous active-low reset.
- round_tick_i  in  1  one-cycle strobe marking a round boundary (LED_i updates on the same cycle).
- game_en_i  in  1  scoring enable.
- clear_i  in  1  synchronous clear of score/streak/best.
- LED_i  in  N_MOLES  lit moles.
- whack_i  in  N_MOLES  buttons, already debounced and synchronised.
- score_o  out  SCORE_W  current score.
- streak_o  out  STREAK_W  consecutive hits.
- best_streak_o  out  STREAK_W  highest streak since clear/reset.
- hit_o  out  1  one-cycle pulse on a scored hit.
- miss_o  out  1  one-cycle pulse on a wrong press.
- escape_o  out  1  one-cycle pulse when a lit round ends unwhacked.
- locked_o  out  1  high while in LOCKED.

Behaviour:
- Reset (async, reset_n_i=0):
  - All outputs 0; state ARMED.
  - whack_q set to all ones, so buttons held through reset do not register.
- Edge detect: press = whack_i & ~whack_q; whack_q <= whack_i every cycle, including when disabled.
- Press classification:
  - Hit: press has any edge on a lit LED bit (press & LED_i non-zero). Hit wins over miss when both occur in one cycle.
  - Miss: press non-zero and no edge on a lit bit.
- FSM, two states:
  - ARMED -> LOCKED on hit or miss.
  - LOCKED -> ARMED on round_tick_i.
  - Presses in LOCKED are ignored (edge consumed, no pulse).
- round_tick_i forces next state ARMED in every case:
  - ARMED, press and tick in the same cycle: press is scored, state stays ARMED.
  - LOCKED, press and tick in the same cycle: press is ignored, state becomes ARMED.
- Escape: round_tick_i in ARMED, no press that cycle, LED_i non-zero -> escape_o=1 and streak cleared; score unchanged.
- Hit arithmetic:
  - streak <= sat(streak+1).
  - score <= sat(score + HIT_POINTS + bonus), with bonus=1 when BONUS_EVERY!=0 and (streak+1) mod BONUS_EVERY == 0.
  - Sums computed at SCORE_W+2 bits, then clamped to 2^SCORE_W-1.
  - best_streak <= max(best_streak, new streak).
- Miss arithmetic: streak <= 0; score <= score >= MISS_PENALTY ? score-MISS_PENALTY : 0 (floor 0, no wrap).
- Latency: all outputs and pulses are registered and update the cycle after the whack_i edge or tick is sampled.
- game_en_i=0:
  - No hit/miss/escape, counters hold, state forced ARMED.
  - Edge register still tracks, so a button held across enable does not score.
- clear_i: zeroes score, streak and best_streak and forces ARMED. It has priority over any same-cycle hit or miss; pulses are suppressed that cycle.
- Mid-game reset: async, takes effect immediately, regardless of state.

Test Plan:
- Defaults, LED_i=00100, rising edge on whack_i[2] -> next cycle hit_o=1, score_o=1, streak_o=1, locked_o=1; a second edge on [2] before the tick -> no change.
- LED_i=00100, edges on whack_i[2] and whack_i[0] in the same cycle -> hit (score+1), miss_o stays 0. Then after a tick, edge on whack_i[4] with LED_i=00100 -> miss_o=1, score back down by 1, streak_o=0.
- Five consecutive hit rounds from 0 -> score_o=6 (bonus on the 5th), best_streak_o=5. Then a tick with LED_i=01000 and no press -> escape_o=1, streak_o=0, best_streak_o=5, score_o=6.
- SCORE_W=4, score preloaded to 15 via hits -> a further hit keeps score_o=15. At score 0 a miss keeps score_o=0.
- Press edge and round_tick_i in the same cycle:
  - in ARMED -> scored and locked_o=0 next cycle;
  - in LOCKED -> no pulse and locked_o=0.
- reset_n_i low mid-LOCKED, asynchronously between clock edges -> outputs zero immediately. Button held through reset release -> no hit. game_en_i=0 with edges -> counters hold.
